// File: rtl/mcu_cmd_pkg.sv
// Shared constants for the MCU command decoder: opcodes, status codes,
// FSM state encoding and frame field positions.
package mcu_cmd_pkg;

    localparam logic [7:0] OP_LED_WR  = 8'h01;
    localparam logic [7:0] OP_REG_WR  = 8'h02;
    localparam logic [7:0] OP_REG_RD  = 8'h03;
    localparam logic [7:0] OP_ID_RD   = 8'h04;
    localparam logic [7:0] OP_CLR_OVR = 8'h05;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_OP   = 8'hE1;
    localparam logic [7:0] ST_BAD_ADDR = 8'hE2;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_EXEC = 3'b010,
        S_RESP = 3'b100
    } state_t;

    // Command frame: opcode, address, wdata. Response frame adds status/seq/flag.
    localparam int unsigned F_OP_LSB   = 56;
    localparam int unsigned F_ADDR_LSB = 48;
    localparam int unsigned F_ST_LSB   = 48;
    localparam int unsigned F_SEQ_LSB  = 40;
    localparam int unsigned F_OVR_LSB  = 32;
    localparam int unsigned F_DATA_LSB = 0;

    function automatic logic [63:0] build_resp(input logic [7:0]  op,
                                               input logic [7:0]  st,
                                               input logic [7:0]  seq,
                                               input logic        ovr,
                                               input logic [31:0] data);
        return {op, st, seq, 7'b0, ovr, data};
    endfunction

endpackage

// File: rtl/cmd_regfile.sv
// Configuration register bank: synchronous write port, combinational read
// port and a flattened view of every register.
module cmd_regfile #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic [31:0]              o_rdata,
    output logic [NUM_REGS*32-1:0]   o_flat
);

    logic [31:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

    always_comb begin
        o_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) o_flat[32*i +: 32] = r_mem[i];
    end

endmodule

// File: rtl/mcu_cmd_decoder.sv
// Executes 64-bit SPI command frames in the CLK domain and returns one
// response frame per accepted command over a valid/ready handshake.
module mcu_cmd_decoder
    import mcu_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter logic [31:0] ID_WORD  = 32'hE7C1_0001,
    parameter logic [7:0]  LED_INIT = 8'h00
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [63:0]             RX_DATA,
    input  logic                    RX_VLD,
    output logic [63:0]             TX_DATA,
    output logic                    TX_VLD,
    input  logic                    TX_RDY,
    output logic [7:0]              LED,
    output logic [NUM_REGS*32-1:0]  REG_FLAT,
    output logic                    BUSY,
    output logic                    OVERRUN
);

    localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_op, r_addr, r_seq, r_led;
    logic [31:0] r_wdata;
    logic [63:0] r_tx_data;
    logic        r_tx_vld, r_ovr;

    logic        w_accept, w_drop, w_exec, w_ovr_nxt;
    logic        w_addr_ok, w_led_we, w_reg_we, w_clr;
    logic [7:0]  w_status;
    logic [31:0] w_resp_data, w_reg_rd;
    logic        w_unused;

    assign w_unused = &{1'b0, RX_DATA[47:32]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A frame arriving on the completing handshake cycle is a new command, not a drop.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: if (RX_VLD) begin
                w_accept    = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_drop      = RX_VLD;
                w_state_nxt = S_RESP;
            end
            S_RESP: if (r_tx_vld && TX_RDY) begin
                w_state_nxt = RX_VLD ? S_EXEC : S_IDLE;
                w_accept    = RX_VLD;
            end else begin
                w_drop      = RX_VLD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_addr_ok = {1'b0, r_addr} < NREGS9;

    always_comb begin
        w_status    = ST_OK;
        w_resp_data = '0;
        w_led_we    = 1'b0;
        w_reg_we    = 1'b0;
        w_clr       = 1'b0;
        case (r_op)
            OP_LED_WR: begin
                w_led_we    = 1'b1;
                w_resp_data = {24'h0, r_wdata[7:0]};
            end
            OP_REG_WR: if (w_addr_ok) begin
                w_reg_we    = 1'b1;
                w_resp_data = r_wdata;
            end else w_status = ST_BAD_ADDR;
            OP_REG_RD: if (w_addr_ok) w_resp_data = w_reg_rd;
                       else           w_status    = ST_BAD_ADDR;
            OP_ID_RD:   w_resp_data = ID_WORD;
            OP_CLR_OVR: w_clr       = 1'b1;
            default:    w_status    = ST_BAD_OP;
        endcase
    end

    // A drop in the same cycle as CLR_OVR keeps the flag set.
    assign w_ovr_nxt = w_drop | (r_ovr & ~(w_exec & w_clr));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_seq     <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_led     <= LED_INIT;
            r_ovr     <= 1'b0;
        end else begin
            r_ovr <= w_ovr_nxt;
            if (w_accept) begin
                r_op    <= RX_DATA[F_OP_LSB +: 8];
                r_addr  <= RX_DATA[F_ADDR_LSB +: 8];
                r_wdata <= RX_DATA[F_DATA_LSB +: 32];
                r_seq   <= r_seq + 8'd1;
            end
            if (w_exec) begin
                r_tx_vld  <= 1'b1;
                r_tx_data <= build_resp(r_op, w_status, r_seq, w_ovr_nxt, w_resp_data);
                if (w_led_we) r_led <= r_wdata[7:0];
            end else if (r_tx_vld && TX_RDY) begin
                r_tx_vld <= 1'b0;
            end
        end
    end

    cmd_regfile #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_we    (w_exec & w_reg_we),
        .i_waddr (r_addr[ADDR_W-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[ADDR_W-1:0]),
        .o_rdata (w_reg_rd),
        .o_flat  (REG_FLAT)
    );

    assign TX_DATA = r_tx_data;
    assign TX_VLD  = r_tx_vld;
    assign LED     = r_led;
    assign BUSY    = (r_state != S_IDLE);
    assign OVERRUN = r_ovr;

endmodule

// File: tb/tb_mcu_cmd_decoder.sv
// Directed bench for mcu_cmd_decoder with a reference model feeding an
// expected-response queue.
module tb_mcu_cmd_decoder;

    localparam int unsigned NUM_REGS = 16;
    localparam logic [31:0] ID_WORD  = 32'hE7C1_0001;
    localparam logic [7:0]  LED_INIT = 8'h00;

    logic                   CLK = 1'b0;
    logic                   RST_N;
    logic [63:0]            RX_DATA;
    logic                   RX_VLD;
    logic [63:0]            TX_DATA;
    logic                   TX_VLD;
    logic                   TX_RDY;
    logic [7:0]             LED;
    logic [NUM_REGS*32-1:0] REG_FLAT;
    logic                   BUSY;
    logic                   OVERRUN;

    mcu_cmd_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (4),
        .ID_WORD  (ID_WORD),
        .LED_INIT (LED_INIT)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RX_DATA  (RX_DATA),
        .RX_VLD   (RX_VLD),
        .TX_DATA  (TX_DATA),
        .TX_VLD   (TX_VLD),
        .TX_RDY   (TX_RDY),
        .LED      (LED),
        .REG_FLAT (REG_FLAT),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] sb[$];
    logic [7:0]  m_led;
    logic [7:0]  m_seq;
    logic        m_ovr;
    logic [31:0] m_regs [NUM_REGS];
    logic [63:0] last_resp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [NUM_REGS*32-1:0] model_flat();
        logic [NUM_REGS*32-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_led = LED_INIT;
        m_seq = 8'h00;
        m_ovr = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
    endtask

    // Reference behaviour of one accepted command; drop marks a frame lost during its EXEC.
    task automatic model_cmd(input logic [7:0] op, input logic [7:0] addr,
                             input logic [31:0] wd, input bit drop);
        logic [7:0]  st;
        logic [31:0] d;
        st = 8'h00;
        d  = 32'h0;
        m_seq = m_seq + 8'd1;
        case (op)
            8'h01: begin m_led = wd[7:0]; d = {24'h0, wd[7:0]}; end
            8'h02: if (addr < NUM_REGS) begin m_regs[addr] = wd; d = wd; end else st = 8'hE2;
            8'h03: if (addr < NUM_REGS) d = m_regs[addr]; else st = 8'hE2;
            8'h04: d = ID_WORD;
            8'h05: m_ovr = 1'b0;
            default: st = 8'hE1;
        endcase
        if (drop) m_ovr = 1'b1;
        sb.push_back({op, st, m_seq, 7'b0, m_ovr, d});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge (or after EXEC when drop).
    task automatic drive_cmd(input logic [7:0] op, input logic [7:0] addr,
                             input logic [31:0] wd, input bit drop);
        model_cmd(op, addr, wd, drop);
        RX_DATA = {op, addr, 16'hA55A, wd};
        RX_VLD  = 1'b1;
        @(negedge CLK);
        if (drop) begin
            RX_DATA = 64'hFFFF_0000_0000_FFFF;
            @(negedge CLK);
        end
        RX_VLD = 1'b0;
    endtask

    task automatic compare_front(input string tag);
        last_resp = TX_DATA;
        if (sb.size() == 0) check("sb_empty", 64'd0, 64'd1);
        else check(tag, TX_DATA, sb.pop_front());
    endtask

    task automatic collect(input string tag);
        int unsigned n = 0;
        while (!TX_VLD && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!TX_VLD) begin
            check({tag, "_timeout"}, 64'(TX_VLD), 64'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            compare_front(tag);
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [63:0]            hold;
        logic [NUM_REGS*32-1:0] flat_before;
        logic [31:0]            r3;

        RST_N   = 1'b0;
        RX_VLD  = 1'b0;
        RX_DATA = '0;
        TX_RDY  = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_tx_vld",  64'(TX_VLD),  64'd0);
        check("rst_tx_data", TX_DATA,      64'd0);
        check("rst_led",     64'(LED),     64'(LED_INIT));
        check("rst_ovr",     64'(OVERRUN), 64'd0);
        check("rst_busy",    64'(BUSY),    64'd0);
        check("rst_regs",    64'(REG_FLAT != '0), 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // LED write and its two-edge latency
        drive_cmd(8'h01, 8'h00, 32'h0000_00A5, 1'b0);
        check("t1_led_n1",  64'(LED),    64'(LED_INIT));
        check("t1_busy",    64'(BUSY),   64'd1);
        check("t1_vld_n1",  64'(TX_VLD), 64'd0);
        @(negedge CLK);
        check("t1_led_n2",  64'(LED),    64'hA5);
        check("t1_vld_n2",  64'(TX_VLD), 64'd1);
        collect("t1_resp");
        check("t1_literal", last_resp, 64'h01_00_01_00_0000_00A5);

        // register write/readback
        drive_cmd(8'h02, 8'h03, 32'hDEAD_BEEF, 1'b0);
        collect("t2_wr");
        drive_cmd(8'h03, 8'h03, 32'h0, 1'b0);
        collect("t2_rd");
        check("t2_literal", last_resp, 64'h03_00_03_00_DEAD_BEEF);
        r3 = REG_FLAT[127:96];
        check("t2_reg3", 64'(r3), 64'hDEAD_BEEF);
        drive_cmd(8'h02, 8'h0F, 32'h1234_5678, 1'b0);
        collect("t2_wr15");
        check("t2_flat", 64'(REG_FLAT != model_flat()), 64'd0);

        // bad address and bad opcode leave state untouched
        flat_before = REG_FLAT;
        drive_cmd(8'h03, 8'h10, 32'h0, 1'b0);
        collect("t3_rd_bad");
        drive_cmd(8'h02, 8'hFF, 32'hCAFE_F00D, 1'b0);
        collect("t3_wr_bad");
        drive_cmd(8'h7F, 8'h01, 32'h0000_0011, 1'b0);
        collect("t3_badop");
        check("t3_flat_same", 64'(REG_FLAT != flat_before), 64'd0);
        check("t3_led_same",  64'(LED), 64'(m_led));

        // back-pressure holds the response; a frame in the window is dropped
        TX_RDY = 1'b0;
        drive_cmd(8'h04, 8'h00, 32'h0, 1'b0);
        @(negedge CLK);
        hold = TX_DATA;
        for (int i = 0; i < 10; i++) begin
            check("t4_vld_hold",  64'(TX_VLD), 64'd1);
            check("t4_data_hold", TX_DATA, hold);
            if (i == 3) begin
                RX_DATA = {8'h01, 8'h00, 16'h0, 32'h0000_00EE};
                RX_VLD  = 1'b1;
                m_ovr   = 1'b1;
            end else RX_VLD = 1'b0;
            @(negedge CLK);
        end
        check("t4_ovr_set", 64'(OVERRUN), 64'd1);
        check("t4_led_kept", 64'(LED), 64'(m_led));
        TX_RDY = 1'b1;
        collect("t4_id");
        drive_cmd(8'h03, 8'h03, 32'h0, 1'b0);
        collect("t4_rd_ovr");
        drive_cmd(8'h05, 8'h00, 32'h0, 1'b0);
        collect("t4_clr");
        check("t4_ovr_clr", 64'(OVERRUN), 64'd0);

        // drop during EXEC, including the CLR_OVR race
        drive_cmd(8'h04, 8'h00, 32'h0, 1'b1);
        collect("t4b_id_drop");
        drive_cmd(8'h05, 8'h00, 32'h0, 1'b1);
        collect("t4b_clr_drop");
        check("t4b_ovr_kept", 64'(OVERRUN), 64'd1);
        drive_cmd(8'h05, 8'h00, 32'h0, 1'b0);
        collect("t4b_clr");
        check("t4b_ovr_clr", 64'(OVERRUN), 64'd0);

        // new frame on the completing handshake cycle is accepted
        drive_cmd(8'h01, 8'h00, 32'h0000_003C, 1'b0);
        @(negedge CLK);
        check("t5_vld", 64'(TX_VLD), 64'd1);
        compare_front("t5_first");
        model_cmd(8'h02, 8'h05, 32'h0BAD_F00D, 1'b0);
        RX_DATA = {8'h02, 8'h05, 16'h0, 32'h0BAD_F00D};
        RX_VLD  = 1'b1;
        @(negedge CLK);
        RX_VLD = 1'b0;
        check("t5_busy", 64'(BUSY), 64'd1);
        collect("t5_second");
        check("t5_ovr", 64'(OVERRUN), 64'd0);

        // asynchronous reset in RESP
        TX_RDY = 1'b0;
        drive_cmd(8'h01, 8'h00, 32'h0000_005A, 1'b0);
        @(negedge CLK);
        check("t6_vld_pre", 64'(TX_VLD), 64'd1);
        #2 RST_N = 1'b0;
        #1;
        check("t6_vld_rst",  64'(TX_VLD), 64'd0);
        check("t6_led_rst",  64'(LED), 64'(LED_INIT));
        check("t6_regs_rst", 64'(REG_FLAT != '0), 64'd0);
        check("t6_busy_rst", 64'(BUSY), 64'd0);
        model_reset();
        @(negedge CLK);
        RST_N  = 1'b1;
        TX_RDY = 1'b1;
        @(negedge CLK);

        // sequence counter wraps after 256 commands
        for (int i = 0; i < 256; i++) begin
            drive_cmd(8'h04, 8'h00, 32'h0, 1'b0);
            collect("t6_seq");
        end
        check("t6_seq_wrap", 64'(last_resp[47:40]), 64'h00);
        check("t6_sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
